// File: rtl/tug_of_war_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tug_of_war_ctrl                                                  |
// | Purpose : Tug of War game controller. Two player buttons pull a single lit |
// |           LED along a 9-LED playfield. Reaching an end LED wins the round; |
// |           per-player scores are kept and the match ends at MAX_SCORE.      |
// | Ports   : clk        - system clock                                        |
// |           reset_n    - asynchronous active-low reset                       |
// |           key_p1     - P1 button (async, high = pressed), pulls to LED9    |
// |           key_p2     - P2 button (async, high = pressed), pulls to LED1    |
// |           restart    - synchronous, clears scores and starts a new match   |
// |           leds[8:0]  - playfield, one-hot, leds[8]=LED9 .. leds[0]=LED1    |
// |           winner     - 01 = P1, 10 = P2, 00 = none                         |
// |           score_p1/2 - round wins per player                               |
// |           match_over - high in the match-over state                        |
// | Options : TOW_DEBOUNCE_EN - insert a per-key debouncer of DEBOUNCE_CYCLES  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tug_of_war_ctrl #(
  parameter int unsigned HOLD_CYCLES     = 50_000_000,
  parameter int unsigned MAX_SCORE       = 7,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_p1,
  input  logic       key_p2,
  input  logic       restart,
  output logic [8:0] leds,
  output logic [1:0] winner,
  output logic [2:0] score_p1,
  output logic [2:0] score_p2,
  output logic       match_over
);

  localparam int unsigned C_HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [C_HOLD_W-1:0] C_HOLD_LAST = C_HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [2:0] C_MAX    = 3'(MAX_SCORE);
  localparam logic [8:0] C_CENTRE = 9'b000010000;

  typedef enum logic [1:0] {
    ST_PLAY       = 2'd0,
    ST_WIN        = 2'd1,
    ST_MATCH_OVER = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning: per key, 2-flop synchronizer, optional debouncer, then
  // one more flop so a rising level produces a single-cycle press pulse.
  // ---------------------------------------------------------------------------
  logic [1:0] w_key;
  logic [1:0] w_press;

  assign w_key = {key_p2, key_p1};

  genvar k;
  generate
    for (k = 0; k < 2; k++) begin : g_key
      logic r_s1;
      logic r_s2;
      logic r_prev;
      logic w_level;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_s1 <= 1'b0;
          r_s2 <= 1'b0;
        end else begin
          r_s1 <= w_key[k];
          r_s2 <= r_s1;
        end
      end

`ifdef TOW_DEBOUNCE_EN
      localparam int unsigned C_DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
      localparam logic [C_DB_W-1:0] C_DB_LAST = C_DB_W'(DEBOUNCE_CYCLES - 1);
      logic              r_db;
      logic [C_DB_W-1:0] r_db_cnt;

      // The debounced level follows the synchronized level only after it has
      // differed for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_db     <= 1'b0;
          r_db_cnt <= '0;
        end else if (r_s2 == r_db) begin
          r_db_cnt <= '0;
        end else if (r_db_cnt == C_DB_LAST) begin
          r_db     <= r_s2;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end

      assign w_level = r_db;
`else
      assign w_level = r_s2;
`endif

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_prev <= 1'b0;
        end else begin
          r_prev <= w_level;
        end
      end

      assign w_press[k] = w_level & ~r_prev;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Game state machine
  // ---------------------------------------------------------------------------
  state_t              r_state, w_state_nxt;
  logic [8:0]          r_leds, w_leds_nxt;
  logic [1:0]          r_winner, w_winner_nxt;
  logic [2:0]          r_score_p1, w_score_p1_nxt;
  logic [2:0]          r_score_p2, w_score_p2_nxt;
  logic [C_HOLD_W-1:0] r_hold, w_hold_nxt;
  logic [8:0]          w_move;
  logic [2:0]          w_win_score;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_PLAY;
      r_leds     <= C_CENTRE;
      r_winner   <= 2'b00;
      r_score_p1 <= 3'd0;
      r_score_p2 <= 3'd0;
      r_hold     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_leds     <= w_leds_nxt;
      r_winner   <= w_winner_nxt;
      r_score_p1 <= w_score_p1_nxt;
      r_score_p2 <= w_score_p2_nxt;
      r_hold     <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_leds_nxt     = r_leds;
    w_winner_nxt   = r_winner;
    w_score_p1_nxt = r_score_p1;
    w_score_p2_nxt = r_score_p2;
    w_hold_nxt     = r_hold;
    w_move         = r_leds;
    w_win_score    = (r_winner == 2'b01) ? r_score_p1 : r_score_p2;

    case (r_state)
      ST_PLAY: begin
        // Simultaneous presses cancel out.
        if (w_press[0] && !w_press[1]) begin
          w_move     = r_leds << 1;
          w_leds_nxt = w_move;
          if (w_move[8]) begin
            w_state_nxt    = ST_WIN;
            w_winner_nxt   = 2'b01;
            w_hold_nxt     = '0;
            w_score_p1_nxt = (r_score_p1 < C_MAX) ? r_score_p1 + 3'd1 : r_score_p1;
          end
        end else if (w_press[1] && !w_press[0]) begin
          w_move     = r_leds >> 1;
          w_leds_nxt = w_move;
          if (w_move[0]) begin
            w_state_nxt    = ST_WIN;
            w_winner_nxt   = 2'b10;
            w_hold_nxt     = '0;
            w_score_p2_nxt = (r_score_p2 < C_MAX) ? r_score_p2 + 3'd1 : r_score_p2;
          end
        end
      end

      ST_WIN: begin
        if (r_hold == C_HOLD_LAST) begin
          w_hold_nxt = '0;
          if (w_win_score == C_MAX) begin
            w_state_nxt = ST_MATCH_OVER;
          end else begin
            w_state_nxt  = ST_PLAY;
            w_leds_nxt   = C_CENTRE;
            w_winner_nxt = 2'b00;
          end
        end else begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end

      ST_MATCH_OVER: begin
        // Everything frozen until restart or reset.
      end

      default: begin
        w_state_nxt = ST_PLAY;
        w_leds_nxt  = C_CENTRE;
      end
    endcase

    // Restart overrides whatever the state machine decided this cycle.
    if (restart) begin
      w_state_nxt    = ST_PLAY;
      w_leds_nxt     = C_CENTRE;
      w_winner_nxt   = 2'b00;
      w_score_p1_nxt = 3'd0;
      w_score_p2_nxt = 3'd0;
      w_hold_nxt     = '0;
    end
  end

  assign leds       = r_leds;
  assign winner     = r_winner;
  assign score_p1   = r_score_p1;
  assign score_p2   = r_score_p2;
  assign match_over = (r_state == ST_MATCH_OVER);

endmodule
`default_nettype wire

// File: tb/tb_tug_of_war_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_tug_of_war_ctrl                                               |
// | Purpose : Directed self-checking bench for tug_of_war_ctrl with            |
// |           HOLD_CYCLES=4 and MAX_SCORE=2.                                   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_tug_of_war_ctrl;

  logic       clk;
  logic       reset_n;
  logic       key_p1;
  logic       key_p2;
  logic       restart;
  logic [8:0] leds;
  logic [1:0] winner;
  logic [2:0] score_p1;
  logic [2:0] score_p2;
  logic       match_over;

  int tests_run = 0;
  int tests_failed = 0;

  tug_of_war_ctrl #(
    .HOLD_CYCLES    (4),
    .MAX_SCORE      (2),
    .DEBOUNCE_CYCLES(3)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .key_p1    (key_p1),
    .key_p2    (key_p2),
    .restart   (restart),
    .leds      (leds),
    .winner    (winner),
    .score_p1  (score_p1),
    .score_p2  (score_p2),
    .match_over(match_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge; inputs are driven and outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [8:0] e_leds, input logic [1:0] e_win,
                         input logic [2:0] e_s1, input logic [2:0] e_s2, input logic e_mo);
    chk({tag, ".leds"},       leds,               e_leds);
    chk({tag, ".winner"},     {7'd0, winner},     {7'd0, e_win});
    chk({tag, ".score_p1"},   {6'd0, score_p1},   {6'd0, e_s1});
    chk({tag, ".score_p2"},   {6'd0, score_p2},   {6'd0, e_s2});
    chk({tag, ".match_over"}, {8'd0, match_over}, {8'd0, e_mo});
  endtask

  // Full press: 4 cycles held, 3 cycles released; the move lands on edge 3.
  task automatic press(input bit p1, input bit p2);
    key_p1 = p1;
    key_p2 = p2;
    repeat (4) tick();
    key_p1 = 1'b0;
    key_p2 = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    reset_n = 1'b0;
    key_p1  = 1'b0;
    key_p2  = 1'b0;
    restart = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (10) tick();
    chk_all("reset_idle", 9'b000010000, 2'b00, 3'd0, 3'd0, 1'b0);

    // Single held P1 press: moves exactly once, on the third edge.
    key_p1 = 1'b1;
    tick(); tick();
    chk("latency_edge2", leds, 9'b000010000);
    tick();
    chk("latency_edge3", leds, 9'b000100000);
    repeat (17) tick();
    chk("held_no_repeat", leds, 9'b000100000);
    key_p1 = 1'b0;
    repeat (3) tick();

    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk_all("restart1", 9'b000010000, 2'b00, 3'd0, 3'd0, 1'b0);

    // P1 wins a round.
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    chk("p1_three_moves", leds, 9'b010000000);
    key_p1 = 1'b1;
    repeat (3) tick();
    chk_all("p1_win", 9'b100000000, 2'b01, 3'd1, 3'd0, 1'b0);
    key_p1 = 1'b0;
    key_p2 = 1'b1;             // its pulse lands inside the hold and is ignored
    repeat (3) tick();
    chk_all("win_hold_end", 9'b100000000, 2'b01, 3'd1, 3'd0, 1'b0);
    tick();
    chk_all("win_to_play", 9'b000010000, 2'b00, 3'd1, 3'd0, 1'b0);
    key_p2 = 1'b0;
    repeat (3) tick();
    chk("p2_press_in_win_dropped", leds, 9'b000010000);

    // Simultaneous presses cancel, then one P2 press.
    press(1'b1, 1'b1);
    chk("both_pressed", leds, 9'b000010000);
    press(1'b0, 1'b1);
    chk("p2_one_move", leds, 9'b000001000);

    // P2 wins round 1 of 2.
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    key_p2 = 1'b1;
    repeat (3) tick();
    chk_all("p2_win1", 9'b000000001, 2'b10, 3'd1, 3'd1, 1'b0);
    key_p2 = 1'b0;
    repeat (4) tick();
    chk_all("p2_win1_to_play", 9'b000010000, 2'b00, 3'd1, 3'd1, 1'b0);

    // P2 wins round 2 of 2 -> match over.
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    key_p2 = 1'b1;
    repeat (3) tick();
    chk_all("p2_win2", 9'b000000001, 2'b10, 3'd1, 3'd2, 1'b0);
    key_p2 = 1'b0;
    repeat (4) tick();
    chk_all("match_over", 9'b000000001, 2'b10, 3'd1, 3'd2, 1'b1);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk_all("match_frozen", 9'b000000001, 2'b10, 3'd1, 3'd2, 1'b1);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk_all("restart2", 9'b000010000, 2'b00, 3'd0, 3'd0, 1'b0);

    // Asynchronous reset in the middle of a win hold.
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    key_p1 = 1'b1;
    repeat (3) tick();
    chk_all("p1_win_again", 9'b100000000, 2'b01, 3'd1, 3'd0, 1'b0);
    key_p1 = 1'b0;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk_all("async_reset", 9'b000010000, 2'b00, 3'd0, 3'd0, 1'b0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    press(1'b1, 1'b0);
    chk_all("after_reset_move", 9'b000100000, 2'b00, 3'd0, 3'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tug_of_war_ctrl.md
Name: tug_of_war_ctrl

Overview:
- Game controller for the Tug of War lab.
- Takes the two player push-buttons and moves a single lit LED along the 9-LED playfield (LED9..LED1).
- Detects a round win when the light reaches an end LED, keeps per-player scores and ends the match at a target score.
- Its leds[8] (LED9) and leds[0] (LED1) outputs feed the existing victory HEX decoder directly.

Parameters:
- HOLD_CYCLES, 50_000_000: cycles the round-win display is held before the next round starts; legal range >= 1.
- MAX_SCORE, 7: round wins needed to end the match; legal range 1..7.
- DEBOUNCE_CYCLES, 1_000_000: stable-input cycles required per button; used only with TOW_DEBOUNCE_EN.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- key_p1  input  1  player 1 button, asynchronous, active-high pressed; pulls the light toward LED9
- key_p2  input  1  player 2 button, asynchronous, active-high pressed; pulls the light toward LED1
- restart  input  1  synchronous, active-high; clears the scores and starts a new match
- leds  output  9  playfield; leds[8]=LED9 ... leds[0]=LED1; exactly one bit set at all times
- winner  output  2  2'b01 = P1 won the current round/match, 2'b10 = P2, 2'b00 = none
- score_p1  output  3  P1 round wins
- score_p2  output  3  P2 round wins
- match_over  output  1  high once either score reaches MAX_SCORE

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-low.
  - Reset values: leds=9'b000010000 (LED5, centre), winner=2'b00, score_p1=0, score_p2=0, match_over=0, state=PLAY.
- Input conditioning:
  - Each key passes through a 2-flop synchronizer, then a third flop for rising-edge detection.
  - Produces a one-cycle press pulse per key.
  - A held key produces exactly one pulse.
- Latency: with key_pN rising before clk edge 1, leds updates on edge 3.
- State machine (states PLAY, WIN, MATCH_OVER):
  - PLAY:
    - Pulse on P1 only: light moves one position toward LED9.
    - Pulse on P2 only: light moves one position toward LED1.
    - Both pulses in the same cycle: no movement.
    - If the move lands on LED9: go to WIN, winner=01, score_p1 increments, all on the same edge.
    - If the move lands on LED1: go to WIN, winner=10, score_p2 increments, all on the same edge.
  - WIN:
    - All press pulses are ignored; leds holds the end LED; a hold counter runs from 0.
    - After HOLD_CYCLES cycles in WIN: if the winner's score == MAX_SCORE, go to MATCH_OVER.
    - Otherwise go to PLAY with leds=centre and winner=00.
  - MATCH_OVER:
    - match_over=1; leds, winner and the scores are frozen.
    - Presses are ignored; only restart or reset leaves this state.
- Scores: saturate at MAX_SCORE and never wrap.
- restart, valid in any state and taking priority over a same-cycle press:
  - Next edge: state=PLAY, leds=centre, winner=00, both scores=0, match_over=0, hold counter cleared.
- Reset asserted mid-round or mid-hold: immediately returns to the reset values; synchronizer flops clear to 0.
- The light can never move past LED9 or LED1, because reaching an end LED leaves PLAY.

Optional Feature:
- Macro: TOW_DEBOUNCE_EN.
- Defined:
  - Each synchronized key feeds a debouncer; the debounced level changes only after the input has been stable and different for DEBOUNCE_CYCLES consecutive cycles.
  - Edge detection uses the debounced level.
  - Latency becomes 3 + DEBOUNCE_CYCLES edges.
- Undefined: no debouncer logic exists, and edge detection uses the synchronized level directly.

Test Plan:
- Reset, then idle 10 cycles -> leds=9'b000010000, winner=00, both scores 0, match_over=0.
- Single P1 press held 20 cycles -> leds becomes 9'b000100000 on the 3rd edge after the rise, then no further change; the held key does not move the light again.
- Four P1 presses with HOLD_CYCLES=4 -> leds=9'b100000000, winner=01, score_p1=1. Presses during WIN are ignored. After 4 cycles: leds=centre, winner=00.
- P1 and P2 pressed on the same cycle -> leds unchanged; then one P2 press -> leds=9'b000001000.
- MAX_SCORE=2: P2 wins two rounds -> score_p2=2, match_over=1, leds=9'b000000001, winner=10. Presses are then ignored. A restart pulse clears to the reset values on the next edge.
- Reset asserted during WIN hold with score_p1=1 -> all outputs return to reset values asynchronously; after release, a P1 press moves the light from centre.
